// File: rtl/cpu_pkg.sv
// Shared CPU constants: multiply/divide op encodings, MDU FSM state codes,
// and the quotient returned on divide-by-zero.
// No ports; imported with `import cpu_pkg::*;`.
package cpu_pkg;

  // Multiply/divide op encodings (op[1] = signed, op[0] = divide)
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  // MDU FSM states
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  // Quotient returned on divide-by-zero; wide enough for WIDTH up to 64
  localparam logic [63:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
// Ports: rem_i/div_i/bit_i in, rem_o/q_o out (purely combinational).
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, div_i};
  // Compare rather than use the borrow bit: with a zero divisor the partial
  // remainder is not bounded by the divisor, so the shifted value can exceed
  // 2^WIDTH and the borrow would lie. This way a zero divisor yields an
  // all-ones quotient and the remainder ends up equal to the dividend.
  assign q_o     = (shifted >= {1'b0, div_i});
  assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/ex_muldiv.sv
// Iterative EX-stage multiply/divide unit owning HI/LO. One bit per cycle,
// WIDTH RUN cycles per op; busy stalls the pipeline, done pulses at completion.
// Ports: clk, reset (async high), start/op/x/y request, flush abort,
//        hi_we/lo_we/wdata for MTHI/MTLO, busy/done/dz status, hi/lo results.
// Optional: define MDU_SIGNED_EN to make op[1] select signed MULT/DIV.
module ex_muldiv
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] m_q, m_d;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_q, acc_d;  // product high half / partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;    // multiplier->product low / dividend->quotient
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             dz_q, dz_d, done_q, done_d;

  logic [WIDTH-1:0] x_mag, y_mag;
  logic [WIDTH-1:0] acc_n, sh_n, res_hi, res_lo;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] drem;
  logic             dq;
  logic             last, res_dz;

`ifdef MDU_SIGNED_EN
  logic x_neg, y_neg;
  logic neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] prod;
  assign x_neg = op[1] & x[WIDTH-1];
  assign y_neg = op[1] & y[WIDTH-1];
  assign x_mag = x_neg ? -x : x;
  assign y_mag = y_neg ? -y : y;
`else
  logic unused_op1;
  assign unused_op1 = op[1];
  assign x_mag = x;
  assign y_mag = y;
`endif

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_q),
    .div_i (m_q),
    .bit_i (sh_q[WIDTH-1]),
    .rem_o (drem),
    .q_o   (dq)
  );

  // Shift-add: add multiplicand into the high half when the multiplier LSB is
  // set, then shift the whole {carry, acc, sh} right by one.
  assign mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, m_q} : '0);

  always_comb begin
    if (is_div_q) begin
      acc_n = drem;
      sh_n  = {sh_q[WIDTH-2:0], dq};
    end else begin
      acc_n = mul_sum[WIDTH:1];
      sh_n  = {mul_sum[0], sh_q[WIDTH-1:1]};
    end
  end

  assign last   = (cnt_q == CNT_W'(WIDTH - 1));
  assign res_dz = is_div_q && (m_q == '0);

  // Completion-cycle result, including sign fix-up when enabled
  always_comb begin
    res_hi = acc_n;
    res_lo = sh_n;
`ifdef MDU_SIGNED_EN
    prod = {acc_n, sh_n};
    if (is_div_q) begin
      if (neg_res_q) res_lo = -sh_n;
      if (neg_rem_q) res_hi = -acc_n;
    end else if (neg_res_q) begin
      prod   = -prod;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
`endif
    // Remainder already equals the original dividend on divide-by-zero
    if (res_dz) res_lo = DZ_QUOTIENT[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    m_d      = m_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
`ifdef MDU_SIGNED_EN
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !flush) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          is_div_d = op[0];
          m_d      = op[0] ? y_mag : x_mag;
          acc_d    = '0;
          sh_d     = op[0] ? x_mag : y_mag;
`ifdef MDU_SIGNED_EN
          neg_res_d = x_neg ^ y_neg;
          neg_rem_d = x_neg;
`endif
        end
      end
      default: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          acc_d = acc_n;
          sh_d  = sh_n;
          if (last) begin
            state_d = ST_IDLE;
            hi_d    = res_hi;
            lo_d    = res_lo;
            dz_d    = res_dz;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      m_q      <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
`ifdef MDU_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
`ifdef MDU_SIGNED_EN
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
